uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmit line among `NUM_REQ` byte producers. It arbitrates round-robin and serializes the granted byte as 8N1 (1 start bit, 8 data bits LSB-first, 1 stop bit), one bit per `baud_tick` pulse from the free-running baud tick generator. It sits between the application-side byte sources and the board TX pin, replacing a dedicated per-source transmitter.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16, need not be a power of two.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `grant_id`.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset. Asserted when 0.
- `baud_tick`  in  1: single-cycle pulse, one per bit period, from the baud tick generator. Spacing between pulses is at least 2 `clk` cycles.
- `req_valid`  in  `NUM_REQ`: bit i high means requester i holds a byte.
- `req_data`  in  `NUM_REQ*8`: byte i is at `[8*i+7 : 8*i]`.
- `req_ready`  out  `NUM_REQ`: one-hot, single-cycle accept pulse. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx`  out  1: serial line, registered, idles high.
- `busy`  out  1: high from the cycle after accept until the frame ends.
- `grant_id`  out  `ID_W`: index of the requester that owns the current or last frame.

## Operation
- FSM states: IDLE, SYNC, START, DATA, STOP.
- **IDLE**
  - `tx`=1, `busy`=0.
  - If any `req_valid` bit is set, select the winner by round-robin. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - In the same cycle: pulse `req_ready[winner]`, latch its byte into the shift register, set `last_grant`=`grant_id`=winner, and go to SYNC.
  - `baud_tick` is ignored in IDLE.
- **SYNC**
  - `tx`=1.
  - On `baud_tick`, go to START. This aligns the start bit to a bit-period boundary.
- **START**
  - `tx`=0.
  - On `baud_tick`, go to DATA with `bit_cnt`=0.
- **DATA**
  - `tx`=`shreg[0]`.
  - On `baud_tick`: if `bit_cnt`==7, go to STOP; otherwise shift `shreg` right by one and increment `bit_cnt`.
- **STOP**
  - `tx`=1.
  - On `baud_tick`, go to IDLE.
- Only one `req_ready` bit is ever high, and only in IDLE.
- `req_valid` deasserting in any state other than IDLE has no effect. The latched byte is always sent in full.
- Requesters that lose arbitration keep `req_valid` high. They are served in round-robin order and none can be starved: each waits at most `NUM_REQ-1` frames.
- `bit_cnt` is 3 bits. `last_grant` is `ID_W` bits, and its wrap is explicit at `NUM_REQ-1` (not a power-of-two overflow).

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
  - FSM=IDLE.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously and the byte is discarded.
  - After release, the first arbitration favours requester 0.
- Accept latency: `req_ready` is high in the same cycle that IDLE sees `req_valid`.
- Bit boundaries:
  - `tx` changes on the `clk` edge after each `baud_tick` cycle.
  - The start-bit falling edge follows the first `baud_tick` seen in SYNC.
- Frame duration from first `tx`=0 to the return to IDLE: exactly 10 tick periods.
- Accept to start bit: between 1 cycle and 1 tick period, plus 1 cycle.
- Back-to-back frames:
  - The return to IDLE takes one cycle, then a new accept happens.
  - The next start bit waits for the following tick, so the stop bit lasts at least 1 tick period.
- `busy` is high while the FSM is in SYNC, START, DATA or STOP.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles with `req_valid`=4'b1111 → `tx`=1, `req_ready`=0, `busy`=0. After release, the first `req_ready`=4'b0001.
- **Single frame:** tick every 4 clocks, requester 2 sends 8'hA5 → `req_ready`=4'b0100 for 1 cycle, `grant_id`=2. `tx` sequence per tick is 0,1,0,1,0,0,1,0,1,1. `busy` falls after the stop tick.
- **Round-robin:** all four requesters valid continuously with bytes 8'h10..8'h13 → grant order 0,1,2,3,0, with no repeat before a wrap.
- **Non-power-of-two:** `NUM_REQ`=3, requesters 0 and 2 valid → grants alternate 0,2,0. `grant_id` never shows 3.
- **Mid-frame changes:** drop `req_valid` during DATA → the frame completes unchanged. Assert reset during bit 4 → `tx`=1 in the same cycle. After release, the next frame starts from arbitration in IDLE.
- **Tick alignment:** issue the accept 1 cycle after a tick → the start bit begins after the next tick, and every bit lasts exactly 4 clocks.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// One bit per baud_tick; tx is registered and idles high.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id
);

   localparam int SW = ID_W + 1;

   typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_shreg, w_shreg_nxt;
   logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
   logic [ID_W-1:0]     r_last_grant, w_last_grant_nxt;
   logic [ID_W-1:0]     r_grant_id, w_grant_id_nxt;
   logic                r_tx, w_tx_nxt;

   logic                w_found;
   logic [ID_W-1:0]     w_winner;
   logic [ID_W-1:0]     w_idx;
   logic [SW-1:0]       w_sum;
   logic [NUM_REQ-1:0]  w_grant_oh;
   logic [7:0]          w_byte;

   // Search from last_grant+1 with an explicit wrap at NUM_REQ, so
   // non-power-of-two counts never produce an out-of-range index.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      w_sum    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_sum = {1'b0, r_last_grant} + SW'(k);
         if (w_sum >= SW'(NUM_REQ))
            w_sum = w_sum - SW'(NUM_REQ);
         w_idx = w_sum[ID_W-1:0];
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      w_grant_oh = '0;
      w_byte     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_found && (w_winner == ID_W'(i))) begin
            w_grant_oh[i] = 1'b1;
            w_byte        = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_shreg_nxt      = r_shreg;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_last_grant_nxt = r_last_grant;
      w_grant_id_nxt   = r_grant_id;
      req_ready        = '0;
      case (r_state)
         IDLE: begin
            // rst gates the accept pulse so nothing is offered while held in reset
            if (rst && w_found) begin
               req_ready        = w_grant_oh;
               w_shreg_nxt      = w_byte;
               w_last_grant_nxt = w_winner;
               w_grant_id_nxt   = w_winner;
               w_state_nxt      = SYNC;
            end
         end
         SYNC: begin
            if (baud_tick) w_state_nxt = START;
         end
         START: begin
            if (baud_tick) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_shreg_nxt   = {1'b0, r_shreg[7:1]};
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_tick) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shreg_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_tx         <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_shreg      <= w_shreg_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_grant_id   <= w_grant_id_nxt;
         r_tx         <= w_tx_nxt;
      end
   end

   assign tx       = r_tx;
   assign busy     = (r_state != IDLE);
   assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance and a
// 3-requester instance sharing clock, reset and a 4-clock baud tick.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        baud_tick;

   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic        tx, busy;
   logic [1:0]  grant_id;

   logic [2:0]  req_valid3, req_ready3;
   logic [23:0] req_data3;
   logic        tx3, busy3;
   logic [1:0]  grant_id3;

   int   total = 0;
   int   bad   = 0;
   int   ph    = 0;
   logic last_tick = 1'b0;
   int   rr_exp[5] = '{0, 1, 2, 3, 0};
   int   nr_exp[3] = '{0, 2, 0};

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx(tx), .busy(busy), .grant_id(grant_id)
   );

   uart_tx_arbiter #(.NUM_REQ(3)) dut3 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
      .tx(tx3), .busy(busy3), .grant_id(grant_id3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; records whether that edge carried a tick, then schedules the next tick.
   task automatic cyc();
      @(posedge clk);
      last_tick = baud_tick;
      #1;
      baud_tick = (ph == 3);
      ph = (ph + 1) % 4;
   endtask

   task automatic wait_tick(input string tag);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 16; n++) begin
         cyc();
         if (last_tick) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("%s_tick_timeout", tag), 32'(got), 32'd1);
   endtask

   task automatic wait_idle(input logic sel3, input string tag);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
         cyc();
         if (!(sel3 ? busy3 : busy)) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("%s_idle_timeout", tag), 32'(got), 32'd1);
   endtask

   task automatic wait_accept(input logic sel3, input string tag, output int idx);
      logic [15:0] r;
      logic        got;
      got = 1'b0;
      idx = -1;
      for (int n = 0; n < 200; n++) begin
         #1;
         r = sel3 ? {13'b0, req_ready3} : {12'b0, req_ready};
         if (r != '0) begin
            got = 1'b1;
            chk($sformatf("%s_onehot", tag), 32'($onehot(r)), 32'd1);
            for (int i = 0; i < 16; i++)
               if (r[i]) idx = i;
            cyc();
            break;
         end
         cyc();
      end
      chk($sformatf("%s_accept_timeout", tag), 32'(got), 32'd1);
   endtask

   task automatic accept_main(input logic [3:0] exp_oh, input logic [1:0] exp_id, input string tag);
      #1;
      chk($sformatf("%s_ready", tag), 32'(req_ready), 32'(exp_oh));
      cyc();
      chk($sformatf("%s_grant_id", tag), 32'(grant_id), 32'(exp_id));
      chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] b, input int drop_at);
      logic [9:0] e;
      e = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         wait_tick(tag);
         chk($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(e[i]));
         if (i == drop_at) begin
            req_valid = '0;
            req_data  = '1;
         end
      end
      wait_tick(tag);
      chk($sformatf("%s_busy_end", tag), 32'(busy), 32'd0);
      chk($sformatf("%s_tx_end", tag), 32'(tx), 32'd1);
   endtask

   initial begin
      int idx;
      int n;

      rst        = 1'b0;
      baud_tick  = 1'b0;
      req_valid  = 4'hF;
      req_data   = 32'h13121110;
      req_valid3 = '0;
      req_data3  = '0;

      // Reset with all requesters valid
      repeat (5) cyc();
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_tx3", 32'(tx3), 32'd1);
      chk("rst_busy3", 32'(busy3), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_first_ready", 32'(req_ready), 32'd1);

      // Round-robin with everyone valid
      for (int k = 0; k < 5; k++) begin
         wait_accept(1'b0, $sformatf("rr%0d", k), idx);
         chk($sformatf("rr%0d_winner", k), 32'(idx), 32'(rr_exp[k]));
         chk($sformatf("rr%0d_grant_id", k), 32'(grant_id), 32'(rr_exp[k]));
      end
      req_valid = '0;
      wait_idle(1'b0, "rr");

      // Single frame from requester 2
      req_valid = 4'b0100;
      req_data  = 32'h00A50000;
      accept_main(4'b0100, 2'd2, "single");
      req_valid = '0;
      frame_check("single", 8'hA5, -1);

      // Requester 1 drops valid and scribbles data mid-frame
      req_valid = 4'b0010;
      req_data  = 32'h00003C00;
      accept_main(4'b0010, 2'd1, "drop");
      frame_check("drop", 8'h3C, 3);

      // Accept one cycle after a tick; bit widths must be 4 clocks
      wait_tick("align");
      req_valid = 4'b1000;
      req_data  = 32'hA5000000;
      accept_main(4'b1000, 2'd3, "align");
      req_valid = '0;
      n = 0;
      for (int c = 0; c < 20; c++) begin cyc(); n++; if (tx == 1'b0) break; end
      chk("align_to_start", 32'(n), 32'd3);
      n = 0;
      for (int c = 0; c < 20; c++) begin cyc(); n++; if (tx != 1'b0) break; end
      chk("align_start_len", 32'(n), 32'd4);
      n = 0;
      for (int c = 0; c < 20; c++) begin cyc(); n++; if (tx != 1'b1) break; end
      chk("align_bit0_len", 32'(n), 32'd4);
      wait_idle(1'b0, "align");

      // Reset during data bit 4
      req_valid = 4'b0010;
      req_data  = 32'h0;
      accept_main(4'b0010, 2'd1, "rstmid");
      req_valid = '0;
      for (int i = 0; i < 6; i++) wait_tick("rstmid");
      chk("rstmid_bit4", 32'(tx), 32'd0);
      cyc();
      #1;
      req_valid = 4'hF;
      rst = 1'b0;
      #1;
      chk("rstmid_tx", 32'(tx), 32'd1);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_grant_id", 32'(grant_id), 32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd0);
      cyc();
      cyc();
      #1;
      rst = 1'b1;
      #1;
      chk("rstmid_first_ready", 32'(req_ready), 32'd1);
      cyc();
      chk("rstmid_regrant", 32'(grant_id), 32'd0);
      chk("rstmid_rebusy", 32'(busy), 32'd1);
      req_valid = '0;
      wait_idle(1'b0, "rstmid");

      // Three requesters, 0 and 2 valid
      req_valid3 = 3'b101;
      req_data3  = 24'h222120;
      for (int k = 0; k < 3; k++) begin
         wait_accept(1'b1, $sformatf("nr%0d", k), idx);
         chk($sformatf("nr%0d_winner", k), 32'(idx), 32'(nr_exp[k]));
         chk($sformatf("nr%0d_grant_id", k), 32'(grant_id3), 32'(nr_exp[k]));
         chk($sformatf("nr%0d_not3", k), 32'(grant_id3 != 2'd3), 32'd1);
      end
      req_valid3 = '0;
      wait_idle(1'b1, "nr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
